// File: rtl/klotski_pkg.sv
// Shared types for the klotski MoveZero sequencer: board, mask, position, command and error codes.
package klotski_pkg;

  typedef logic [3:0][3:0][3:0] board_t;   // [row][col] 4-bit tile, 0 = blank
  typedef logic [3:0][3:0]      mask_t;    // 1 = blank may not enter this cell
  typedef logic [1:0][1:0]      pos_t;     // [1] = row, [0] = col

  typedef struct packed {
    pos_t       target;
    mask_t      mask;
    logic       flag;
    logic [3:0] num_pos;
  } move_cmd_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_TARGET  = 2'd2
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_CHECK = 2'd3
  } state_e;

  function automatic logic [3:0] tile_at(input board_t b, input pos_t p);
    return b[p[1]][p[0]];
  endfunction

endpackage

// File: rtl/move_cmd_fifo.sv
// Command FIFO for the MoveZero sequencer; flush drops everything, including a same-cycle push.
module move_cmd_fifo
  import klotski_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  logic      i_push,
  input  move_cmd_t i_data,
  input  logic      i_pop,
  input  logic      i_flush,
  output move_cmd_t o_data,
  output logic      o_full,
  output logic      o_empty
);

  localparam int AW = $clog2(DEPTH);

  move_cmd_t     mem [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          do_push, do_pop;

  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = i_push && !o_full && !i_flush;
  assign do_pop  = i_pop && !o_empty && !i_flush;
  assign o_data  = mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= i_data;
  end

  // NOTE: sequential state uses non-blocking <= so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/move_zero_sequencer.sv
// Issues queued blank-move commands to an external MoveZero, chains result boards, checks the blank
// lands on target, and reports timeout / wrong-target errors.
module move_zero_sequencer
  import klotski_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  board_t     i_board,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  pos_t       i_cmd_target,
  input  mask_t      i_cmd_mask,
  input  logic       i_cmd_flag,
  input  logic [3:0] i_cmd_num_pos,
  input  logic       i_run,
  input  logic       i_abort,
  output logic       o_mz_start,
  output board_t     o_mz_klotski,
  output pos_t       o_mz_target,
  output mask_t      o_mz_mask,
  output logic       o_mz_flag,
  output logic [3:0] o_mz_num_pos,
  input  board_t     i_mz_klotski,
  input  logic       i_mz_finished,
  output board_t     o_board,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  output logic [1:0] o_err_code,
  output logic [7:0] o_step_count
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  move_cmd_t        cmd_q, cmd_d;
  board_t           board_q, board_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [7:0]       step_q, step_d;
  logic             err_q, err_d;
  err_e             err_code_q, err_code_d;
  logic             done_q, done_d;

  move_cmd_t        fifo_head;
  logic             fifo_full, fifo_empty, fifo_pop, fifo_flush;
  logic             wait_expired, target_blocked;

  move_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (i_cmd_valid),
    .i_data  ('{target: i_cmd_target, mask: i_cmd_mask, flag: i_cmd_flag, num_pos: i_cmd_num_pos}),
    .i_pop   (fifo_pop),
    .i_flush (fifo_flush),
    .o_data  (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign wait_expired   = (wait_cnt_q == CNT_W'(TIMEOUT));
  assign target_blocked = (tile_at(board_q, cmd_q.target) != 4'd0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: combinational blocks assign a default first, so no path leaves a signal unassigned (no latch).
  always_comb begin
    state_d = state_q;
    if (i_abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (i_run && !fifo_empty) state_d = ST_ISSUE;
        ST_ISSUE: state_d = ST_WAIT;
        ST_WAIT:  if (i_mz_finished) state_d = ST_CHECK;
                  else if (wait_expired) state_d = ST_IDLE;
        ST_CHECK: state_d = (target_blocked || fifo_empty) ? ST_IDLE : ST_ISSUE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_mz_start = (state_q == ST_ISSUE);
    o_busy     = (state_q != ST_IDLE);
  end

  // Datapath next-state; the command register is loaded on entry to ISSUE so operands are valid there.
  always_comb begin
    board_d    = board_q;
    cmd_d      = cmd_q;
    wait_cnt_d = wait_cnt_q;
    step_d     = step_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    done_d     = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = i_abort;
    if (!i_abort) begin
      case (state_q)
        ST_IDLE: begin
          if (i_load) begin
            board_d    = i_board;
            err_d      = 1'b0;
            err_code_d = ERR_NONE;
          end
          if (i_run) begin
            err_d      = 1'b0;
            err_code_d = ERR_NONE;
            step_d     = 8'd0;
            if (fifo_empty) begin
              done_d = 1'b1;
            end else begin
              fifo_pop = 1'b1;
              cmd_d    = fifo_head;
            end
          end
        end
        ST_ISSUE: wait_cnt_d = CNT_W'(1);
        ST_WAIT: begin
          if (i_mz_finished) begin
            board_d = i_mz_klotski;
          end else if (wait_expired) begin
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
            fifo_flush = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
        end
        ST_CHECK: begin
          if (target_blocked) begin
            err_d      = 1'b1;
            err_code_d = ERR_TARGET;
            fifo_flush = 1'b1;
          end else begin
            if (step_q != 8'hFF) step_d = step_q + 8'd1;
            if (fifo_empty) begin
              done_d = 1'b1;
            end else begin
              fifo_pop = 1'b1;
              cmd_d    = fifo_head;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      board_q    <= '0;
      cmd_q      <= '0;
      wait_cnt_q <= '0;
      step_q     <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      done_q     <= 1'b0;
    end else begin
      board_q    <= board_d;
      cmd_q      <= cmd_d;
      wait_cnt_q <= wait_cnt_d;
      step_q     <= step_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      done_q     <= done_d;
    end
  end

  assign o_cmd_ready  = !fifo_full;
  assign o_mz_klotski = board_q;
  assign o_mz_target  = cmd_q.target;
  assign o_mz_mask    = cmd_q.mask;
  assign o_mz_flag    = cmd_q.flag;
  assign o_mz_num_pos = cmd_q.num_pos;
  assign o_board      = board_q;
  assign o_done       = done_q;
  assign o_err        = err_q;
  assign o_err_code   = err_code_q;
  assign o_step_count = step_q;

endmodule
